kianv_uart_rx: RTL
==================

// Module: kianv_uart_rx
// PURPOSE
//  UART receiver, 8N1, LSB first: the stage directly downstream of the SoC uart_tx pin.
//  Decodes the serial line into bytes and buffers them in a FIFO with a valid/ready pop port.
//  Used by the bench to check firmware console output, and on board as a console input path.
// PARAMETERS
//  SYSTEM_CLK  50_000_000  clock frequency in Hz
//  BAUDRATE    115200      line rate; CPB = SYSTEM_CLK/BAUDRATE (truncating), HALF = CPB/2
//  FIFO_DEPTH  16          receive FIFO entries; must be a power of 2 and >= 2
// PORTS
//  clk        in   1   system clock, all logic on the rising edge
//  resetn     in   1   synchronous reset, active low
//  rx         in   1   asynchronous serial input, idle high
//  rx_data    out  8   byte at the FIFO head; valid only while rx_valid=1
//  rx_valid   out  1   FIFO not empty
//  rx_ready   in   1   consumer pops the head on a cycle where rx_valid & rx_ready
//  rx_level   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  frame_err  out  1   one-cycle pulse: stop bit sampled low
//  overrun    out  1   one-cycle pulse: byte dropped because the FIFO was full
// BEHAVIOUR
//  - Sync: rx passes through 2 flops (reset value 1); a third flop holds the previous
//    synced value for edge detection. All decoding uses the synced value rxs.
//  - Reset (resetn=0 at a clk edge): state IDLE, bit counter 0, FIFO empty,
//    rx_valid=0, rx_level=0, frame_err=0, overrun=0, rx_data=0. Any partial frame is discarded.
//  - FSM, one down-counter cnt:
//    IDLE:  falling edge on rxs (prev 1, now 0) -> START, cnt=HALF-1.
//           A continuously low line does not retrigger.
//    START: when cnt==0, sample rxs. 0 -> DATA, cnt=CPB-1, bit index 0.
//           1 -> IDLE (glitch rejected, no pulse).
//    DATA:  when cnt==0, shift rxs into bit[idx] (LSB first) and reload cnt=CPB-1.
//           After idx 7 -> STOP.
//    STOP:  when cnt==0, sample rxs. 1 -> push byte. 0 -> frame_err pulse, byte dropped.
//           Either way -> IDLE in the same cycle, so a back-to-back start edge is caught.
//    All samples fall at bit mid-point +/-1 clk.
//  - Latency: push occurs at 2+HALF+9*CPB (+/-2) clks after the rx falling edge.
//    rx_valid rises the cycle after the push.
//  - FIFO:
//    - Circular buffer with wrap-around pointers. rx_data is the registered head.
//    - Push with FIFO not full: byte stored, rx_level+1.
//    - Push with FIFO full and no pop in that cycle: byte dropped, overrun pulse,
//      contents unchanged.
//    - Push and pop in the same cycle (including full): both take effect, rx_level unchanged.
//    - Pop with FIFO empty is ignored.
//    - rx_data/rx_valid change only after a pop or a push into an empty FIFO.
//  - frame_err and overrun are never asserted in the same cycle; each stays high exactly 1 clk.
// TESTING  (SYSTEM_CLK=50e6, BAUDRATE=115200 -> CPB=434, bench drives rx at 434 clk/bit)
//  1. Frame 0x55, rx_ready=0 -> within 4130 clks rx_valid=1, rx_data=0x55, rx_level=1.
//     Pulse rx_ready for 1 clk -> rx_valid=0, rx_level=0.
//  2. rx low for 100 clks, then high -> no push, frame_err=0, FSM back in IDLE.
//     A following 0xA3 frame is received correctly.
//  3. Frame 0xA3 with stop bit driven low -> frame_err pulses once, rx_level stays 0.
//     A following 0x3C frame is received correctly.
//  4. 17 frames 0x00..0x10, rx_ready=0 -> rx_level=16, one overrun pulse on the 17th frame.
//     Draining yields 0x00..0x0F in order.
//  5. Back-to-back frames 0xFF,0x00,0x81 with no idle gap, rx_ready=1 ->
//     three bytes popped in order, no errors.
//  6. resetn=0 for 1 clk during data bit 4 of a frame -> no byte pushed from that frame.
//     The next complete 0x7E frame yields rx_data=0x7E.

Source files
------------

// File: rtl/kianv_uart_rx.sv
// kianv_uart_rx_fifo / kianv_uart_rx : 8N1 UART receiver feeding a circular byte FIFO.
// Latency: byte visible on rx_data/rx_valid one cycle after the stop-bit sample (~2+HALF+9*CPB clks after the start edge).
// Backpressure: valid/ready pop port; no backpressure on the line, bytes arriving into a full FIFO are dropped and flagged.
//
// kianv_uart_rx ports:
//   clk, resetn            rising-edge clock, synchronous active-low reset
//   rx                     asynchronous serial input, idle high
//   rx_data/rx_valid       registered FIFO head and not-empty flag
//   rx_ready               pop request, honoured when rx_valid is high
//   rx_level               FIFO occupancy
//   frame_err / overrun    one-cycle event pulses

// Circular buffer holding received bytes. The head word is kept in its own
// register so the consumer sees a flop output rather than a memory read.
//   push_i/push_dat_i  write request (dropped when full and not popping)
//   pop_i              pop request (ignored when empty)
//   head_o/vld_o       registered head word and not-empty flag
//   level_o            occupancy, drop_o pulses one cycle after a dropped push
module kianv_uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   vld_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             drop_q, drop_d;
  logic             empty, full, pop_ok, push_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign pop_ok  = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_i && (!full || pop_ok);
  assign rd_next = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    drop_d   = push_i && !push_ok;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_next;

    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + ONE_LVL;
      2'b01:   level_d = level_q - ONE_LVL;
      default: level_d = level_q;
    endcase

    // Head refresh: the incoming byte becomes the head when nothing else is
    // queued ahead of it; otherwise a pop exposes the next stored entry. When
    // full with push+pop, the write lands in the slot being vacated, never in
    // rd_next, so the read below is unaffected.
    if (push_ok && (empty || (pop_ok && level_q == ONE_LVL))) begin
      head_d = push_dat_i;
    end else if (pop_ok && level_q > ONE_LVL) begin
      head_d = mem_q[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      drop_q   <= drop_d;
    end
  end

  assign head_o  = head_q;
  assign vld_o   = !empty;
  assign level_o = level_q;
  assign drop_o  = drop_q;

endmodule

module kianv_uart_rx #(
  parameter int SYSTEM_CLK = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int CPB   = SYSTEM_CLK / BAUDRATE;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB + 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Two-flop synchroniser plus one history flop for edge detection. All
  // reset to the idle-high line level so reset never fakes a start edge.
  logic rx_meta_q, rxs_q, rxs_prev_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_vld;
  logic             ferr_d, ferr_q;
  logic             fall, tick;

  assign fall = rxs_prev_q && !rxs_q;
  assign tick = (cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fall) state_d = S_START;
      // A line back high at mid start bit was a glitch: return to idle quietly.
      S_START: if (tick) state_d = rxs_q ? S_IDLE : S_DATA;
      S_DATA:  if (tick && idx_q == 3'd7) state_d = S_STOP;
      // Leave STOP at its mid-point so a back-to-back start edge is not missed.
      S_STOP:  if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic: bit timer, bit index, shift register, events
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_vld = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) cnt_d = CNT_HALF;
      end
      S_START: begin
        if (tick) begin
          cnt_d = CNT_BIT;
          idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d[idx_q] = rxs_q;
          cnt_d          = CNT_BIT;
          idx_d          = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (tick) begin
          byte_vld = rxs_q;
          ferr_d   = !rxs_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
    end
  end

  // Framing error and overrun both come from the single STOP sample and are
  // registered identically, so they can never coincide.
  kianv_uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (byte_vld),
    .push_dat_i (shift_d),
    .pop_i      (rx_ready),
    .head_o     (rx_data),
    .vld_o      (rx_valid),
    .level_o    (rx_level),
    .drop_o     (overrun)
  );

  assign frame_err = ferr_q;

endmodule
